// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and the default frame timeout.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin arbiter. The search starts one past the last
// granted index and wraps modulo NUM_REQ. The first requester found wins.
module uart_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] winner
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NUM_REQ);

  logic [IDW-1:0]     cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  // Candidate gi is the index at rotation distance gi+1 from the last grant.
  // The sum never exceeds 2*NUM_REQ-1, so one conditional subtract wraps it.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum          = {1'b0, last_grant} + (IDW+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  // Priority pick: the closest candidate in rotation order wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        valid  = 1'b1;
        winner = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: arbitrates byte requesters round-robin and
// hands one byte at a time to a UART transmitter.
// Optional frame timeout: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_din_rdy,
  output logic [7:0]                 tx_data,
  input  logic                       tx_start,
  input  logic                       tx_stop,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t             state_reg, state_next;
  logic [IDW-1:0]     last_grant_reg, last_grant_next;
  logic [IDW-1:0]     grant_id_reg, grant_id_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic [NUM_REQ-1:0] req_ready_reg, req_ready_next;
  logic               arb_valid;
  logic [IDW-1:0]     arb_win;
  logic               timeout;

  uart_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .valid      (arb_valid),
    .winner     (arb_win)
  );

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;

  // The counter restarts on entry to each of LOAD and SEND, so each phase
  // gets TIMEOUT_CYC cycles.
  assign timeout = (cnt_reg == CW'(TIMEOUT_CYC - 1));
  assign err     = err_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= IDW'(NUM_REQ - 1);
      grant_id_reg   <= '0;
      tx_data_reg    <= 8'h00;
      req_ready_reg  <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt_reg        <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_id_reg   <= grant_id_next;
      tx_data_reg    <= tx_data_next;
      req_ready_reg  <= req_ready_next;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      cnt_reg        <= cnt_next;
      err_reg        <= err_next;
`endif
    end
  end

  // Next-state logic. The accept pulse is registered, so it appears
  // in the first LOAD cycle.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_id_next   = grant_id_reg;
    tx_data_next    = tx_data_reg;
    req_ready_next  = '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    cnt_next        = '0;
    err_next        = err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          req_ready_next[arb_win] = 1'b1;
          tx_data_next            = req_data[{arb_win, 3'b000} +: 8];
          grant_id_next           = arb_win;
          state_next              = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // tx_start wins even when tx_stop is also high.
        if (tx_start) begin
          state_next = ST_SEND;
        end else if (timeout) begin
          state_next      = ST_IDLE;
          last_grant_next = grant_id_reg;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          err_next        = 1'b1;
`endif
        end else begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
          cnt_next = cnt_reg + 1'b1;
`endif
        end
      end
      ST_SEND: begin
        if (tx_stop) begin
          state_next = ST_DRAIN;
        end else if (timeout) begin
          state_next      = ST_IDLE;
          last_grant_next = grant_id_reg;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          err_next        = 1'b1;
`endif
        end else begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
          cnt_next = cnt_reg + 1'b1;
`endif
        end
      end
      ST_DRAIN: begin
        // Wait for the stop bit to end so a long stop cannot retrigger.
        if (!tx_stop) begin
          state_next      = ST_IDLE;
          last_grant_next = grant_id_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready  = req_ready_reg;
  assign tx_din_rdy = (state_reg == ST_LOAD);
  assign busy       = (state_reg != ST_IDLE);
  assign tx_data    = tx_data_reg;
  assign grant_id   = grant_id_reg;

endmodule
